// File: rtl/hs_reg_slice.sv
// hs_reg_slice: chain of STAGE_NUM two-entry skid buffers cutting data, valid and ready paths.
// Optional HS_REG_SLICE_CNT_EN adds cnt_o, a wrapping count of downstream transfers.
module hs_reg_slice #(
    parameter int DATA_WIDTH = 32,
    parameter int STAGE_NUM  = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  vld_i,
    output logic                  rdy_o,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic                  vld_o,
    input  logic                  rdy_i,
    output logic [DATA_WIDTH-1:0] dat_o
`ifdef HS_REG_SLICE_CNT_EN
    ,
    output logic [31:0]           cnt_o
`endif
);
    typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;

    logic [STAGE_NUM:0]  vld;
    logic [STAGE_NUM:0]  rdy;
    logic [DATA_WIDTH-1:0] dat [STAGE_NUM+1];

    assign vld[0]         = vld_i;
    assign dat[0]         = dat_i;
    assign rdy[STAGE_NUM] = rdy_i;
    assign rdy_o          = rdy[0];
    assign vld_o          = vld[STAGE_NUM];
    assign dat_o          = dat[STAGE_NUM];

    for (genvar s = 0; s < STAGE_NUM; s++) begin : g_stage
        state_t                st;
        logic                  rdy_q;
        logic [DATA_WIDTH-1:0] main_q;
        logic [DATA_WIDTH-1:0] skid_q;
        logic                  push;
        logic                  pop;
        assign push       = vld[s] & rdy_q;
        assign pop        = vld[s+1] & rdy[s+1];
        assign vld[s+1]   = st != EMPTY;
        assign rdy[s]     = rdy_q;
        assign dat[s+1]   = main_q;
        // ready is its own flop so it can be held low during reset
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                st     <= EMPTY;
                rdy_q  <= 1'b0;
                main_q <= '0;
                skid_q <= '0;
            end else begin
                rdy_q <= 1'b1;
                case (st)
                    EMPTY: if (push) begin
                        st     <= BUSY;
                        main_q <= dat[s];
                    end
                    BUSY: if (push && pop) begin
                        main_q <= dat[s];
                    end else if (push) begin
                        st     <= FULL;
                        skid_q <= dat[s];
                        rdy_q  <= 1'b0;
                    end else if (pop) begin
                        st <= EMPTY;
                    end
                    FULL: if (pop) begin
                        st     <= BUSY;
                        main_q <= skid_q;
                    end else begin
                        rdy_q <= 1'b0;
                    end
                    default: st <= EMPTY;
                endcase
            end
        end
    end

`ifdef HS_REG_SLICE_CNT_EN
    logic [31:0] cnt;
    always_ff @(posedge clk_i) begin
        cnt <= rst_i ? 32'd0 : cnt + {31'd0, vld_o & rdy_i};
    end
    assign cnt_o = cnt;
`endif
endmodule

// File: tb/tb_hs_reg_slice.sv
// tb_hs_reg_slice: directed checks of the register slice at 0, 1 and 3 stages.
module tb_hs_reg_slice;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vld = 1'b0;
    logic        rdy = 1'b0;
    logic [31:0] dat = '0;
    logic        rdy_o0, vld_o0, rdy_o1, vld_o1, rdy_o3, vld_o3;
    logic [31:0] dat_o0, dat_o1, dat_o3;
    int          total = 0;
    int          bad = 0;
`ifdef HS_REG_SLICE_CNT_EN
    logic [31:0] cnt_o0, cnt_o1, cnt_o3;
`endif

    always #5 clk = ~clk;

    hs_reg_slice #(.DATA_WIDTH(32), .STAGE_NUM(0)) u0 (
        .clk_i(clk), .rst_i(rst), .vld_i(vld), .rdy_o(rdy_o0), .dat_i(dat),
        .vld_o(vld_o0), .rdy_i(rdy), .dat_o(dat_o0)
`ifdef HS_REG_SLICE_CNT_EN
        , .cnt_o(cnt_o0)
`endif
    );
    hs_reg_slice #(.DATA_WIDTH(32), .STAGE_NUM(1)) u1 (
        .clk_i(clk), .rst_i(rst), .vld_i(vld), .rdy_o(rdy_o1), .dat_i(dat),
        .vld_o(vld_o1), .rdy_i(rdy), .dat_o(dat_o1)
`ifdef HS_REG_SLICE_CNT_EN
        , .cnt_o(cnt_o1)
`endif
    );
    hs_reg_slice #(.DATA_WIDTH(32), .STAGE_NUM(3)) u3 (
        .clk_i(clk), .rst_i(rst), .vld_i(vld), .rdy_o(rdy_o3), .dat_i(dat),
        .vld_o(vld_o3), .rdy_i(rdy), .dat_o(dat_o3)
`ifdef HS_REG_SLICE_CNT_EN
        , .cnt_o(cnt_o3)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vld = 1'b0;
        rdy = 1'b0;
        dat = '0;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        vld = 1'b0;
        rdy = 1'b0;
        repeat (3) step();
        total++;
        if (vld_o1 !== 1'b0 || dat_o1 !== 32'd0 || rdy_o1 !== 1'b0) begin
            bad++;
            $display("FAIL reset_s1: vld=%b rdy=%b dat=%h, want 0 0 0", vld_o1, rdy_o1, dat_o1);
        end
        total++;
        if (vld_o3 !== 1'b0 || dat_o3 !== 32'd0 || rdy_o3 !== 1'b0) begin
            bad++;
            $display("FAIL reset_s3: vld=%b rdy=%b dat=%h, want 0 0 0", vld_o3, rdy_o3, dat_o3);
        end
        rst = 1'b0;
        step();
        total++;
        if (rdy_o1 !== 1'b1 || rdy_o3 !== 1'b1 || vld_o1 !== 1'b0) begin
            bad++;
            $display("FAIL release: rdy1=%b rdy3=%b vld1=%b, want 1 1 0", rdy_o1, rdy_o3, vld_o1);
        end
    endtask

    task automatic test_passthrough();
        logic [31:0] exp_d;
        exp_d = 32'hC0DE_0001;
        vld = 1'b1;
        rdy = 1'b1;
        dat = exp_d;
        #1;
        total++;
        if (vld_o0 !== 1'b1 || rdy_o0 !== 1'b1 || dat_o0 !== exp_d) begin
            bad++;
            $display("FAIL pass0_a: vld=%b rdy=%b dat=%h, want 1 1 %h", vld_o0, rdy_o0, dat_o0, exp_d);
        end
        vld = 1'b0;
        rdy = 1'b0;
        #1;
        total++;
        if (vld_o0 !== 1'b0 || rdy_o0 !== 1'b0) begin
            bad++;
            $display("FAIL pass0_b: vld=%b rdy=%b, want 0 0", vld_o0, rdy_o0);
        end
        do_reset();
    endtask

    task automatic test_streaming();
        logic [31:0] exp_d [3];
        exp_d = '{32'h11, 32'h22, 32'h33};
        rdy = 1'b1;
        vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dat = exp_d[i];
            step();
            total++;
            if (vld_o1 !== 1'b1 || dat_o1 !== exp_d[i] || rdy_o1 !== 1'b1) begin
                bad++;
                $display("FAIL stream_%0d: vld=%b rdy=%b dat=%h, want 1 1 %h", i, vld_o1, rdy_o1, dat_o1, exp_d[i]);
            end
        end
        vld = 1'b0;
        step();
        total++;
        if (vld_o1 !== 1'b0) begin
            bad++;
            $display("FAIL stream_drain: vld=%b, want 0", vld_o1);
        end
    endtask

    task automatic test_backpressure();
        rdy = 1'b0;
        vld = 1'b1;
        dat = 32'hA0;
        step();
        total++;
        if (rdy_o1 !== 1'b1 || dat_o1 !== 32'hA0) begin
            bad++;
            $display("FAIL bp_first: rdy=%b dat=%h, want 1 a0", rdy_o1, dat_o1);
        end
        dat = 32'hA1;
        step();
        total++;
        if (rdy_o1 !== 1'b0 || vld_o1 !== 1'b1 || dat_o1 !== 32'hA0) begin
            bad++;
            $display("FAIL bp_full: rdy=%b vld=%b dat=%h, want 0 1 a0", rdy_o1, vld_o1, dat_o1);
        end
        dat = 32'hA2;
        step();
        total++;
        if (rdy_o1 !== 1'b0 || dat_o1 !== 32'hA0) begin
            bad++;
            $display("FAIL bp_hold: rdy=%b dat=%h, want 0 a0", rdy_o1, dat_o1);
        end
        rdy = 1'b1;
        step();
        total++;
        if (dat_o1 !== 32'hA1 || rdy_o1 !== 1'b1 || vld_o1 !== 1'b1) begin
            bad++;
            $display("FAIL bp_out1: dat=%h rdy=%b vld=%b, want a1 1 1", dat_o1, rdy_o1, vld_o1);
        end
        step();
        total++;
        if (dat_o1 !== 32'hA2 || vld_o1 !== 1'b1) begin
            bad++;
            $display("FAIL bp_out2: dat=%h vld=%b, want a2 1", dat_o1, vld_o1);
        end
        vld = 1'b0;
        step();
        total++;
        if (vld_o1 !== 1'b0) begin
            bad++;
            $display("FAIL bp_drain: vld=%b, want 0", vld_o1);
        end
    endtask

    task automatic test_alternating();
        int idx = 0;
        int got = 0;
        int cyc = 0;
        int push_cyc = -1;
        int first_vld = -1;
        logic push, pop;
        do_reset();
        vld = 1'b1;
        dat = 32'd0;
        while (got < 16 && cyc < 200) begin
            rdy = (cyc % 2) == 0;
            #1;
            push = vld && rdy_o3;
            pop = vld_o3 && rdy;
            if (vld_o3 && first_vld < 0) first_vld = cyc;
            if (push && push_cyc < 0) push_cyc = cyc;
            if (pop) begin
                total++;
                if (dat_o3 !== 32'(got)) begin
                    bad++;
                    $display("FAIL alt_beat_%0d: dat=%h, want %h", got, dat_o3, got);
                end
                got++;
            end
            step();
            cyc++;
            if (push) begin
                idx++;
                dat = 32'(idx);
                if (idx == 16) vld = 1'b0;
            end
        end
        total++;
        if (got != 16) begin
            bad++;
            $display("FAIL alt_count: got=%0d, want 16", got);
        end
        total++;
        if (first_vld - push_cyc != 3) begin
            bad++;
            $display("FAIL alt_latency: latency=%0d, want 3", first_vld - push_cyc);
        end
        vld = 1'b0;
        rdy = 1'b1;
        repeat (4) step();
    endtask

    task automatic test_mid_reset();
        do_reset();
        rdy = 1'b0;
        vld = 1'b1;
        dat = 32'h5;
        step();
        dat = 32'h6;
        step();
        total++;
        if (rdy_o1 !== 1'b0 || dat_o1 !== 32'h5) begin
            bad++;
            $display("FAIL mid_full: rdy=%b dat=%h, want 0 5", rdy_o1, dat_o1);
        end
        rst = 1'b1;
        dat = 32'h7;
        step();
        rst = 1'b0;
        vld = 1'b0;
        rdy = 1'b1;
        total++;
        if (vld_o1 !== 1'b0 || dat_o1 !== 32'd0) begin
            bad++;
            $display("FAIL mid_reset: vld=%b dat=%h, want 0 0", vld_o1, dat_o1);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (vld_o1 !== 1'b0) begin
                bad++;
                $display("FAIL mid_after_%0d: vld=%b dat=%h, want vld 0", i, vld_o1, dat_o1);
            end
        end
    endtask

`ifdef HS_REG_SLICE_CNT_EN
    task automatic test_counter();
        do_reset();
        total++;
        if (cnt_o1 !== 32'd0) begin
            bad++;
            $display("FAIL cnt_reset: cnt=%0d, want 0", cnt_o1);
        end
        rdy = 1'b1;
        vld = 1'b1;
        for (int i = 0; i < 10; i++) begin
            dat = 32'(i);
            step();
        end
        vld = 1'b0;
        step();
        total++;
        if (cnt_o1 !== 32'd10) begin
            bad++;
            $display("FAIL cnt_ten: cnt=%0d, want 10", cnt_o1);
        end
        force u1.cnt = 32'hFFFF_FFFF;
        #1;
        release u1.cnt;
        vld = 1'b1;
        step();
        vld = 1'b0;
        step();
        total++;
        if (cnt_o1 !== 32'd0) begin
            bad++;
            $display("FAIL cnt_wrap: cnt=%h, want 0", cnt_o1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_passthrough();
        test_streaming();
        test_backpressure();
        test_alternating();
        test_mid_reset();
`ifdef HS_REG_SLICE_CNT_EN
        test_counter();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
